// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/2-write register file.
// REGFILE_BYPASS_EN selects write-first read bypass in regfile_2r2w.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
  localparam int CNT_MAX    = 2 ** CNT_W_DEF - 1;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_if.sv
// Write, read and collision-debug signals of the register file.
// REGFILE_BYPASS_EN does not change this bundle.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W-1:0] raddr0;
  logic [DATA_W-1:0] rdata0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              wr_collision;
  logic [CNT_W-1:0]  collision_cnt;

  modport master (
    output we0, waddr0, wdata0,
    output we1, waddr1, wdata1,
    output raddr0, raddr1,
    input  rdata0, rdata1,
    input  wr_collision, collision_cnt
  );

  modport slave (
    input  we0, waddr0, wdata0,
    input  we1, waddr1, wdata1,
    input  raddr0, raddr1,
    output rdata0, rdata1,
    output wr_collision, collision_cnt
  );
endinterface

// File: rtl/regfile_wdec.sv
// Enable-gated one-hot write-address decoder.
// Unaffected by REGFILE_BYPASS_EN.
module regfile_wdec #(
  parameter int ADDR_W = 5
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] row_en
);
  always_comb begin
    row_en = '0;
    if (en) row_en[addr] = 1'b1;
  end
endmodule

// File: rtl/regfile_2r2w.sv
// 32x32 register file, two write / two combinational read ports.
// Define REGFILE_BYPASS_EN for write-first read bypass.
module regfile_2r2w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave bus
);
  localparam int NUM = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [NUM-1:0]    en0;
  logic [NUM-1:0]    en1;
  logic [NUM-1:0]    wr0;
  logic [NUM-1:0]    wr1;
  logic [NUM-1:0]    keep;
  logic [DATA_W-1:0] rows [NUM];
  logic              coll;
  logic              coll_q;
  logic [CNT_W-1:0]  cnt_q;

  regfile_wdec #(.ADDR_W(ADDR_W)) u_wdec0 (
    .en     (bus.we0),
    .addr   (bus.waddr0),
    .row_en (en0)
  );

  regfile_wdec #(.ADDR_W(ADDR_W)) u_wdec1 (
    .en     (bus.we1),
    .addr   (bus.waddr1),
    .row_en (en1)
  );

  // Row 0 is hardwired when ZERO_REG is set, so it never loads.
  always_comb begin
    keep    = '1;
    keep[0] = (ZERO_REG == 0);
  end

  assign wr0 = en0 & keep;
  assign wr1 = en1 & keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) rows[i] <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (wr1[i])      rows[i] <= bus.wdata1;
        else if (wr0[i]) rows[i] <= bus.wdata0;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = rows[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.we1 && bus.waddr1 == a)
      v = bus.wdata1;
    else if (bus.we0 && bus.waddr0 == a)
      v = bus.wdata0;
`endif
    if (ZERO_REG != 0 && a == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    bus.rdata0 = rd(bus.raddr0);
    bus.rdata1 = rd(bus.raddr1);
  end

  assign coll = bus.we0 && bus.we1
             && (bus.waddr0 == bus.waddr1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= coll;
      if (coll && cnt_q != CMAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.wr_collision  = coll_q;
  assign bus.collision_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_2r2w.sv
// Directed self-checking bench for regfile_2r2w.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_2r2w;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  reg_data_t exp_byp;

  always #5 clk = ~clk;

  regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();
  regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  sbus ();

  regfile_2r2w #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  regfile_2r2w #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .CNT_W(4)
  ) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0 = 1'b0;
    bus.we1 = 1'b0;
  endtask

  initial begin
    bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.raddr0 = '0; bus.raddr1 = '0;
    sbus.we0 = 0; sbus.waddr0 = '0; sbus.wdata0 = '0;
    sbus.we1 = 0; sbus.waddr1 = '0; sbus.wdata1 = '0;
    sbus.raddr0 = '0; sbus.raddr1 = '0;

    #12;
    for (int i = 0; i < 32; i++) begin
      bus.raddr0 = i[4:0];
      bus.raddr1 = 5'(31 - i);
      #1;
      chk("rst_rd0", bus.rdata0, 32'h0);
      chk("rst_rd1", bus.rdata1, 32'h0);
    end
    chk("rst_coll", bus.wr_collision, 1'b0);
    chk("rst_cnt", bus.collision_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    bus.we0 = 1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hDEADBEEF;
    bus.we1 = 1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h12345678;
    step();
    idle();
    bus.raddr0 = 5'd3; bus.raddr1 = 5'd7;
    #1;
    chk("wr_row3", bus.rdata0, 32'hDEADBEEF);
    chk("wr_row7", bus.rdata1, 32'h12345678);
    chk("wr_nocoll", bus.wr_collision, 1'b0);

    bus.waddr0 = 5'd3; bus.wdata0 = 32'h0BADF00D;
    bus.waddr1 = 5'd7; bus.wdata1 = 32'h0BADF00D;
    step();
    chk("we0_off", bus.rdata0, 32'hDEADBEEF);
    chk("we1_off", bus.rdata1, 32'h12345678);

    bus.we0 = 1; bus.waddr0 = 5'd9; bus.wdata0 = 32'hAAAA0000;
    bus.we1 = 1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h5555FFFF;
    step();
    idle();
    bus.raddr0 = 5'd9; bus.raddr1 = 5'd9;
    #1;
    chk("coll_row9", bus.rdata0, 32'h5555FFFF);
    chk("coll_same", bus.rdata1, 32'h5555FFFF);
    chk("coll_flag", bus.wr_collision, 1'b1);
    chk("coll_cnt1", bus.collision_cnt, 16'd1);
    step();
    chk("coll_pulse", bus.wr_collision, 1'b0);
    chk("coll_hold", bus.collision_cnt, 16'd1);

    bus.we0 = 1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFFFFFF;
    step();
    idle();
    bus.raddr0 = 5'd0; bus.raddr1 = 5'd3;
    #1;
    chk("zero_rd", bus.rdata0, 32'h0);
    chk("zero_row3", bus.rdata1, 32'hDEADBEEF);
    bus.raddr0 = 5'd7; bus.raddr1 = 5'd1;
    #1;
    chk("zero_row7", bus.rdata0, 32'h12345678);
    chk("zero_row1", bus.rdata1, 32'h0);

    bus.we0 = 1; bus.waddr0 = 5'd0; bus.wdata0 = 32'h1;
    bus.we1 = 1; bus.waddr1 = 5'd0; bus.wdata1 = 32'h2;
    step();
    idle();
    bus.raddr0 = 5'd0;
    #1;
    chk("z_coll", bus.wr_collision, 1'b1);
    chk("z_cnt2", bus.collision_cnt, 16'd2);
    chk("z_rd", bus.rdata0, 32'h0);

    bus.we0 = 1; bus.waddr0 = 5'd5; bus.wdata0 = 32'h11110005;
    step();
    idle();
    bus.we1 = 1; bus.waddr1 = 5'd5; bus.wdata1 = 32'hCAFE0001;
    bus.raddr0 = 5'd5;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hCAFE0001;
`else
    exp_byp = 32'h11110005;
`endif
    #1;
    chk("byp_rd", bus.rdata0, exp_byp);
    step();
    idle();
    #1;
    chk("byp_after", bus.rdata0, 32'hCAFE0001);

    bus.we1 = 1; bus.waddr1 = 5'd0; bus.wdata1 = 32'h77777777;
    bus.raddr1 = 5'd0;
    #1;
    chk("byp_zero", bus.rdata1, 32'h0);
    step();
    idle();

    sbus.we0 = 1; sbus.waddr0 = 5'd2; sbus.wdata0 = 32'h1;
    sbus.we1 = 1; sbus.waddr1 = 5'd2; sbus.wdata1 = 32'h2;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", sbus.collision_cnt, 4'd14);
    step();
    chk("sat_15", sbus.collision_cnt, 4'd15);
    step();
    step();
    chk("sat_17", sbus.collision_cnt, 4'd15);
    sbus.we0 = 0; sbus.we1 = 0;
    step();
    chk("sat_hold", sbus.collision_cnt, 4'd15);

    bus.we0 = 1; bus.waddr0 = 5'd4; bus.wdata0 = 32'h44444444;
    bus.raddr0 = 5'd4; bus.raddr1 = 5'd3;
    rst_n = 1'b0;
    #1;
    chk("mid_cnt", bus.collision_cnt, 16'h0);
    chk("mid_row3", bus.rdata1, 32'h0);
    @(posedge clk);
    #2;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_row4", bus.rdata0, 32'h0);
    chk("mid_cnt2", bus.collision_cnt, 16'h0);
    chk("mid_scnt", sbus.collision_cnt, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
